// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, default device address, R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    PTR,
    ACK_PTR,
    WDATA,
    ACK_DATA,
    RDATA,
    MACK
  } i2c_state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1100111;
  localparam logic       I2C_RW_WRITE     = 1'b0;
  localparam logic       I2C_RW_READ      = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Chain resets to the idle-bus level so leaving reset does not fake a START.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign o_sda       = w_sda;
  assign o_scl_rise  = w_scl & ~r_scl_d;
  assign o_scl_fall  = ~w_scl & r_scl_d;
  assign o_start_det = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop_det  = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_slave_lcd_receiver.sv
// I2C responder feeding a 32-byte LCD RAM: address match, register pointer, burst write/read.
// States: IDLE wait START | ADDR/PTR/WDATA shift in byte | ACK_* drive ACK | RDATA shift out | MACK master ack
module i2c_slave_lcd_receiver
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2,
  parameter int         PTR_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [PTR_W-1:0] WADD,
  output logic [7:0]       DIN,
  output logic             W,
  output logic [PTR_W-1:0] RADD,
  input  logic [7:0]       RDOUT,
  output logic             busy,
  output logic             frame_done
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset       (reset),
    .i_scl       (scl_in),
    .i_sda       (sda_in),
    .o_sda       (w_sda),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop)
  );

  i2c_state_t       r_state, w_state_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [6:0]       r_shift, w_shift_nxt;
  logic [6:0]       r_tx, w_tx_nxt;
  logic             r_ack_ph, w_ack_ph_nxt;
  logic             r_rw, w_rw_nxt;
  logic             r_sda_oe, w_sda_oe_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0] r_wadd, w_wadd_nxt;
  logic [7:0]       r_din, w_din_nxt;
  logic             r_w, w_w_nxt;
  logic [PTR_W-1:0] r_radd, w_radd_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic [7:0]       w_byte;
  logic [PTR_W-1:0] w_ptr_inc;

  assign w_byte    = {r_shift, w_sda};
  assign w_ptr_inc = r_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tx         <= '0;
      r_ack_ph     <= 1'b0;
      r_rw         <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_ptr        <= '0;
      r_wadd       <= '0;
      r_din        <= '0;
      r_w          <= 1'b0;
      r_radd       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_tx         <= w_tx_nxt;
      r_ack_ph     <= w_ack_ph_nxt;
      r_rw         <= w_rw_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
      r_ptr        <= w_ptr_nxt;
      r_wadd       <= w_wadd_nxt;
      r_din        <= w_din_nxt;
      r_w          <= w_w_nxt;
      r_radd       <= w_radd_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_tx_nxt         = r_tx;
    w_ack_ph_nxt     = r_ack_ph;
    w_rw_nxt         = r_rw;
    w_sda_oe_nxt     = r_sda_oe;
    w_ptr_nxt        = r_ptr;
    w_wadd_nxt       = r_wadd;
    w_din_nxt        = r_din;
    w_w_nxt          = 1'b0;
    w_radd_nxt       = r_radd;
    w_busy_nxt       = r_busy;
    w_frame_done_nxt = 1'b0;

    if (w_start) begin
      w_state_nxt   = ADDR;
      w_bit_cnt_nxt = '0;
      w_ack_ph_nxt  = 1'b0;
      w_sda_oe_nxt  = 1'b0;
    end else if (w_stop) begin
      w_state_nxt      = IDLE;
      w_ack_ph_nxt     = 1'b0;
      w_sda_oe_nxt     = 1'b0;
      w_frame_done_nxt = r_busy;
      w_busy_nxt       = 1'b0;
    end else begin
      case (r_state)
        ADDR, PTR, WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte[6:0];
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_ack_ph_nxt = 1'b0;
              case (r_state)
                ADDR: begin
                  if (w_byte[7:1] == DEV_ADDR) begin
                    w_state_nxt = ACK_ADDR;
                    w_busy_nxt  = 1'b1;
                    w_rw_nxt    = w_byte[0];
                  end else begin
                    w_state_nxt = IDLE;
                  end
                end
                PTR: begin
                  w_ptr_nxt   = w_byte[PTR_W-1:0];
                  w_state_nxt = ACK_PTR;
                end
                default: begin
                  w_wadd_nxt  = r_ptr;
                  w_din_nxt   = w_byte;
                  w_w_nxt     = 1'b1;
                  w_ptr_nxt   = w_ptr_inc;
                  w_state_nxt = ACK_DATA;
                end
              endcase
            end
          end
        end
        ACK_ADDR, ACK_PTR, ACK_DATA: begin
          if (w_scl_fall) begin
            if (!r_ack_ph) begin
              w_ack_ph_nxt = 1'b1;
              w_sda_oe_nxt = 1'b1;
              // Present the read address a full ACK bit early so 1-clk RAM latency is covered.
              if (r_state == ACK_ADDR && r_rw == I2C_RW_READ) w_radd_nxt = r_ptr;
            end else begin
              w_ack_ph_nxt  = 1'b0;
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
              if (r_state == ACK_ADDR) begin
                if (r_rw == I2C_RW_WRITE) begin
                  w_state_nxt = PTR;
                end else begin
                  w_tx_nxt     = RDOUT[6:0];
                  w_sda_oe_nxt = ~RDOUT[7];
                  w_state_nxt  = RDATA;
                end
              end else begin
                w_state_nxt = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (w_scl_fall) begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_sda_oe_nxt = 1'b0;
              w_ack_ph_nxt = 1'b0;
              w_state_nxt  = MACK;
            end else begin
              w_sda_oe_nxt = ~r_tx[6];
              w_tx_nxt     = {r_tx[5:0], 1'b0};
            end
          end
        end
        MACK: begin
          if (!r_ack_ph) begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                w_ack_ph_nxt = 1'b1;
                w_ptr_nxt    = w_ptr_inc;
                w_radd_nxt   = w_ptr_inc;
              end else begin
                w_state_nxt = IDLE;
              end
            end
          end else if (w_scl_fall) begin
            w_ack_ph_nxt  = 1'b0;
            w_bit_cnt_nxt = '0;
            w_tx_nxt      = RDOUT[6:0];
            w_sda_oe_nxt  = ~RDOUT[7];
            w_state_nxt   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe     = r_sda_oe;
  assign WADD       = r_wadd;
  assign DIN        = r_din;
  assign W          = r_w;
  assign RADD       = r_radd;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_i2c_slave_lcd_receiver.sv
// Directed bench: bit-banged I2C master, open-drain bus model, behavioural read RAM and write log.
module tb_i2c_slave_lcd_receiver;
  import i2c_pkg::*;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        sda_oe, W, busy, frame_done;
  logic [4:0]  WADD, RADD;
  logic [7:0]  DIN, RDOUT;
  logic [7:0]  ram [32];
  logic [12:0] wlog [$];
  int          fd_cnt = 0;
  int          oe_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  assign sda_bus = m_sda & ~sda_oe;
  assign RDOUT   = ram[RADD];

  always #5 clk = ~clk;

  i2c_slave_lcd_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (m_scl),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .WADD       (WADD),
    .DIN        (DIN),
    .W          (W),
    .RADD       (RADD),
    .RDOUT      (RDOUT),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always @(negedge clk) begin
    if (W) wlog.push_back({WADD, DIN});
    if (frame_done) fd_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1; tick(2*Q);
      m_scl = 1'b0; tick(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    ack = sda_bus; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic wr_acked(input logic [7:0] b, input string tag);
    logic ack;
    write_byte(b, ack);
    check(tag, 32'(ack), 32'd0);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q);
      m_scl = 1'b1; tick(Q);
      b[i] = sda_bus; tick(Q);
      m_scl = 1'b0;
    end
    tick(Q);
    m_sda = mack; tick(Q);
    m_scl = 1'b1; tick(2*Q);
    m_scl = 1'b0; tick(Q);
  endtask

  initial begin
    logic [7:0] rd;
    logic       ack;
    int         wbase, fbase, obase;

    for (int i = 0; i < 32; i++) ram[i] = 8'h00;
    ram[1] = 8'h5A;
    ram[5] = 8'h31;
    ram[6] = 8'h32;

    tick(4);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wadd", 32'(WADD), 32'd0);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_w", 32'(W), 32'd0);
    check("rst_radd", 32'(RADD), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    tick(10);

    // single write
    wbase = wlog.size(); fbase = fd_cnt;
    i2c_start;
    wr_acked(8'hCE, "w1_addr_ack");
    check("w1_busy", 32'(busy), 32'd1);
    wr_acked(8'h00, "w1_ptr_ack");
    wr_acked(8'h48, "w1_data_ack");
    i2c_stop; tick(10);
    check("w1_wcount", 32'(wlog.size() - wbase), 32'd1);
    if (wlog.size() > wbase) check("w1_write", 32'(wlog[wbase]), {19'd0, 5'd0, 8'h48});
    check("w1_frame_done", 32'(fd_cnt - fbase), 32'd1);
    check("w1_busy_clr", 32'(busy), 32'd0);

    // pointer wrap
    wbase = wlog.size();
    i2c_start;
    wr_acked(8'hCE, "wrap_addr_ack");
    wr_acked(8'h1E, "wrap_ptr_ack");
    wr_acked(8'h41, "wrap_d0_ack");
    wr_acked(8'h42, "wrap_d1_ack");
    wr_acked(8'h43, "wrap_d2_ack");
    i2c_stop; tick(10);
    check("wrap_wcount", 32'(wlog.size() - wbase), 32'd3);
    if (wlog.size() >= wbase + 3) begin
      check("wrap_w0", 32'(wlog[wbase]),   {19'd0, 5'd30, 8'h41});
      check("wrap_w1", 32'(wlog[wbase+1]), {19'd0, 5'd31, 8'h42});
      check("wrap_w2", 32'(wlog[wbase+2]), {19'd0, 5'd0,  8'h43});
    end
    check("wrap_ptr", 32'(dut.r_ptr), 32'd1);

    // read using retained pointer
    i2c_start;
    wr_acked(8'hCF, "ret_addr_ack");
    check("ret_radd", 32'(RADD), 32'd1);
    read_byte(1'b1, rd);
    check("ret_data", 32'(rd), 32'h5A);
    i2c_stop; tick(10);

    // address mismatch
    wbase = wlog.size(); fbase = fd_cnt; obase = oe_cnt;
    i2c_start;
    write_byte(8'hA0, ack);
    check("mis_addr_nack", 32'(ack), 32'd1);
    write_byte(8'h55, ack);
    check("mis_data_nack", 32'(ack), 32'd1);
    check("mis_busy", 32'(busy), 32'd0);
    i2c_stop; tick(10);
    check("mis_sda_oe", 32'(oe_cnt - obase), 32'd0);
    check("mis_wcount", 32'(wlog.size() - wbase), 32'd0);
    check("mis_frame_done", 32'(fd_cnt - fbase), 32'd0);

    // pointer write then repeated-START read
    wbase = wlog.size(); fbase = fd_cnt;
    i2c_start;
    wr_acked(8'hCE, "rd_waddr_ack");
    wr_acked(8'h05, "rd_ptr_ack");
    i2c_start;
    wr_acked(8'hCF, "rd_raddr_ack");
    check("rd_radd0", 32'(RADD), 32'd5);
    read_byte(1'b0, rd);
    check("rd_byte0", 32'(rd), 32'h31);
    check("rd_radd1", 32'(RADD), 32'd6);
    read_byte(1'b1, rd);
    check("rd_byte1", 32'(rd), 32'h32);
    check("rd_release", 32'(sda_oe), 32'd0);
    check("rd_busy_held", 32'(busy), 32'd1);
    i2c_stop; tick(10);
    check("rd_radd_final", 32'(RADD), 32'd6);
    check("rd_wcount", 32'(wlog.size() - wbase), 32'd0);
    check("rd_frame_done", 32'(fd_cnt - fbase), 32'd1);

    // pointer upper bits ignored
    wbase = wlog.size();
    i2c_start;
    wr_acked(8'hCE, "up_addr_ack");
    wr_acked(8'hE3, "up_ptr_ack");
    wr_acked(8'h55, "up_data_ack");
    i2c_stop; tick(10);
    check("up_wcount", 32'(wlog.size() - wbase), 32'd1);
    if (wlog.size() > wbase) check("up_write", 32'(wlog[wbase]), {19'd0, 5'd3, 8'h55});
    check("up_ptr", 32'(dut.r_ptr), 32'd4);

    // reset while the address ACK is being driven
    i2c_start;
    send_bits(8'hCE);
    m_sda = 1'b1; tick(Q);
    check("rst_mid_ack_driven", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_mid_state", 32'(dut.r_state), 32'(IDLE));
    check("rst_mid_busy", 32'(busy), 32'd0);
    tick(3);
    reset = 1'b0;
    tick(5);
    i2c_stop; tick(10);
    fbase = fd_cnt;
    i2c_start;
    wr_acked(8'hCE, "rst_after_ack");
    check("rst_after_busy", 32'(busy), 32'd1);
    i2c_stop; tick(10);
    check("rst_after_frame_done", 32'(fd_cnt - fbase), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_lcd_receiver.md
Name: i2c_slave_lcd_receiver

Overview:
- Spartan-side I2C responder for the LCD write master.
- Oversamples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit device address and receives a register pointer.
- Write transfers store the following bytes into the 32-byte LCD RAM through a WADD/DIN/W write port.
- Read transfers return bytes from the same RAM through the RADD/RDOUT read port.

Parameters:
- DEV_ADDR, 7'b1100111, 7-bit address this responder ACKs.
- SYNC_STAGES, 2, synchronizer depth for scl_in/sda_in (minimum 2).
- PTR_W, 5, pointer width; RAM depth is 2**PTR_W (32).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL rate.
- reset  in  1  synchronous, active-high.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- WADD  out  PTR_W  LCD RAM write address.
- DIN  out  8  LCD RAM write data.
- W  out  1  one-clk write strobe.
- RADD  out  PTR_W  LCD RAM read address.
- RDOUT  in  8  LCD RAM read data; combinational or 1-clk latency.
- busy  out  1  high from an address match until STOP.
- frame_done  out  1  one-clk pulse on STOP following an addressed transfer.

Behaviour:
- Reset values: sda_oe=0, WADD=0, DIN=0, W=0, RADD=0, busy=0, frame_done=0, pointer=0, state=IDLE.
- Synchronization: SCL and SDA each pass through SYNC_STAGES flops. Edges are detected on the synchronized signals: scl_rise, scl_fall.
- START = synchronized SDA falling while synchronized SCL is high. STOP = SDA rising while SCL is high.
- START or STOP takes priority over every state and over bit sampling in the same clk.
- START (including a repeated START): go to ADDR, reset bit count, sda_oe=0.
- STOP: go to IDLE, sda_oe=0. Pulse frame_done if busy was set, then clear busy.
- Timing: sample SDA on scl_rise. Change sda_oe only on scl_fall, except that START, STOP or reset release it immediately.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits MSB first (7 address bits + R/W). After the 8th scl_rise: on match go to ACK_ADDR and set busy; on mismatch go to IDLE.
  - ACK_ADDR: on the next scl_fall set sda_oe=1. On the following scl_fall set sda_oe=0, then:
    - write: go to PTR.
    - read: RADD=pointer, load tx shift register from RDOUT, drive its MSB (sda_oe = ~bit), go to RDATA.
  - PTR: receive 8 bits. pointer = byte[PTR_W-1:0]; upper bits ignored. Go to ACK_PTR.
  - ACK_PTR: ACK as in ACK_ADDR, then go to WDATA.
  - WDATA: receive 8 bits. On the 8th scl_rise: WADD=pointer, DIN=byte, W=1 for exactly one clk, pointer=pointer+1 mod 32 (31 wraps to 0). Go to ACK_DATA.
  - ACK_DATA: ACK, then return to WDATA.
  - RDATA: shift out on each scl_fall; bit 0 is driven after the 7th fall. After the 8th scl_fall release SDA and go to MACK.
  - MACK: sample SDA on scl_rise.
    - 0 (ACK): pointer+1 mod 32, RADD updated, reload tx byte, drive its MSB on the next scl_fall, go to RDATA.
    - 1 (NACK): go to IDLE-wait (busy held until STOP).
- Every received byte is ACKed; there is no overflow or NACK condition.
- Multiple writes in one frame auto-increment with wrap.
- Pointer is retained across frames. A read with no preceding pointer write uses the last pointer.
- Reset mid-transfer: all outputs return to reset values in the next clk and SDA is released; the bus master sees no ACK.

Decomposition:
- Shared package i2c_pkg:
  - state encoding constants: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_DATA, RDATA, MACK.
  - DEV_ADDR default.
  - I2C_RW_WRITE=0, I2C_RW_READ=1.
- One natural sub-module: i2c_bus_sync. It holds the synchronizers plus scl_rise/scl_fall/start_det/stop_det detection and is reusable by the master side.

Test Plan:
- Single write: START, 0xCE (addr 0x67 + W), ptr 0x00, data 0x48, STOP → ACK on all three bytes; one W pulse with WADD=0, DIN=0x48; frame_done pulse.
- Wrap: ptr 0x1E, data 0x41 0x42 0x43 → writes at WADD 30, 31, 0; pointer ends at 1.
- Address mismatch: START, 0xA0, data → sda_oe stays 0 throughout; no W; busy=0; no frame_done.
- Read with repeated START: write ptr 0x05, Sr, 0xCF, master ACK then NACK, with RAM[5]=0x31, RAM[6]=0x32 → SDA carries 0x31 then 0x32; RADD 5 then 6; SDA released after NACK.
- Pointer upper bits: ptr 0xE3, data 0x55 → write at WADD 3.
- Reset asserted mid-byte while sda_oe=1 during an ACK → sda_oe=0 next clk; state IDLE; later START + 0xCE is ACKed normally.
